// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the register-file instruction sequencer.
// Instruction field positions, opcode and FSM encodings, register-file command encodings.
package regfile_seq_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int INSTR_W  = 16;
  localparam int BITPOS_W = $clog2(DATA_W);

  localparam int OP_MSB     = 15;
  localparam int OP_LSB     = 12;
  localparam int RD_MSB     = 11;
  localparam int RD_LSB     = 9;
  localparam int RS0_MSB    = 8;
  localparam int RS0_LSB    = 6;
  localparam int RS1_MSB    = 5;
  localparam int RS1_LSB    = 3;
  localparam int IMM_MSB    = 7;
  localparam int IMM_LSB    = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_MOV  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_LDI  = 4'h7,
    OP_SWAP = 4'h8,
    OP_BSET = 4'h9,
    OP_BCLR = 4'hA,
    OP_SHL  = 4'hB,
    OP_SHR  = 4'hC
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WRITE
  } state_e;

  localparam logic [1:0] RF_BIT_OP_SET = 2'b00;

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_SHR;
  endfunction

  function automatic logic updates_flags(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR) ||
           (op == OP_XOR) || (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/regfile_seq_alu.sv
// Combinational result, carry/borrow and zero for the captured operands and opcode.
module regfile_seq_alu
  import regfile_seq_pkg::*;
(
  input  logic [3:0]          op,
  input  logic [DATA_W-1:0]   opa,
  input  logic [DATA_W-1:0]   opb,
  input  logic [7:0]          imm8,
  input  logic [BITPOS_W-1:0] bitpos,
  output logic [DATA_W-1:0]   result,
  output logic                carry,
  output logic                zero
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // The 17th bit of the widened subtract is the borrow (opa < opb).
  assign sum  = {1'b0, opa} + {1'b0, opb};
  assign diff = {1'b0, opa} - {1'b0, opb};

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_MOV:  result = opa;
      OP_ADD:  {carry, result} = sum;
      OP_SUB:  {carry, result} = diff;
      OP_AND:  result = opa & opb;
      OP_OR:   result = opa | opb;
      OP_XOR:  result = opa ^ opb;
      OP_LDI:  result = {{(DATA_W-8){1'b0}}, imm8};
      OP_BCLR: result = opa & ~(DATA_W'(1) << bitpos);
      OP_SHL:  begin
        result = {opa[DATA_W-2:0], 1'b0};
        carry  = opa[DATA_W-1];
      end
      OP_SHR:  begin
        result = {1'b0, opa[DATA_W-1:1]};
        carry  = opa[0];
      end
      default: ;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/regfile_sequencer.sv
// Four-cycle instruction sequencer (IDLE/READ/EXEC/WRITE) driving the 8x16 register-file port.
// Optional status flags are built when SEQ_FLAGS_EN is defined; otherwise they are tied to 0.
module regfile_sequencer
  import regfile_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [INSTR_W-1:0]  instr,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADDR_W-1:0]   rf_read_addr_0,
  output logic [ADDR_W-1:0]   rf_read_addr_1,
  input  logic [DATA_W-1:0]   rf_read_data_0,
  input  logic [DATA_W-1:0]   rf_read_data_1,
  output logic                rf_write_en,
  output logic                rf_swap_en,
  output logic                rf_bit_op_en,
  output logic [ADDR_W-1:0]   rf_write_addr,
  output logic [DATA_W-1:0]   rf_data_in,
  output logic [1:0]          rf_bit_op,
  output logic [BITPOS_W-1:0] rf_bit_position,
  output logic                zero_flag,
  output logic                carry_flag
);

  state_e state, state_nxt;
  logic   accept;

  logic [3:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [7:0]        imm8_q;
  logic [DATA_W-1:0] opa_q, opb_q;

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry, alu_zero;

  logic                in_bitop;
  logic [ADDR_W-1:0]   read_addr_0_d, read_addr_1_d;
  logic                done_d, err_d, write_en_d, swap_en_d, bit_op_en_d;
  logic [ADDR_W-1:0]   write_addr_d;
  logic [DATA_W-1:0]   data_in_d;
  logic [1:0]          bit_op_d;
  logic [BITPOS_W-1:0] bit_position_d;

  assign instr_ready = (state == ST_IDLE);
  assign busy        = ~instr_ready;
  assign accept      = instr_valid & instr_ready;
  assign in_bitop    = (instr[OP_MSB:OP_LSB] == OP_BSET) || (instr[OP_MSB:OP_LSB] == OP_BCLR);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_READ;
      ST_READ:  state_nxt = ST_EXEC;
      ST_EXEC:  state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs: everything is zero except in the one state it belongs to.
  always_comb begin
    read_addr_0_d  = '0;
    read_addr_1_d  = '0;
    done_d         = 1'b0;
    err_d          = 1'b0;
    write_en_d     = 1'b0;
    swap_en_d      = 1'b0;
    bit_op_en_d    = 1'b0;
    write_addr_d   = '0;
    data_in_d      = '0;
    bit_op_d       = '0;
    bit_position_d = '0;
    if (accept) begin
      read_addr_0_d = in_bitop ? instr[RD_MSB:RD_LSB] : instr[RS0_MSB:RS0_LSB];
      read_addr_1_d = instr[RS1_MSB:RS1_LSB];
    end
    if (state == ST_EXEC) begin
      done_d = 1'b1;
      if (!is_legal(op_q)) begin
        err_d = 1'b1;
      end else begin
        case (op_q)
          OP_NOP: ;
          OP_SWAP: begin
            write_en_d   = 1'b1;
            swap_en_d    = 1'b1;
            write_addr_d = rd_q;
          end
          OP_BSET: begin
            write_en_d     = 1'b1;
            bit_op_en_d    = 1'b1;
            write_addr_d   = rd_q;
            bit_op_d       = RF_BIT_OP_SET;
            bit_position_d = imm8_q[BITPOS_W-1:0];
          end
          default: begin
            write_en_d   = 1'b1;
            write_addr_d = rd_q;
            data_in_d    = alu_result;
          end
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_read_addr_0  <= '0;
      rf_read_addr_1  <= '0;
      done            <= 1'b0;
      err             <= 1'b0;
      rf_write_en     <= 1'b0;
      rf_swap_en      <= 1'b0;
      rf_bit_op_en    <= 1'b0;
      rf_write_addr   <= '0;
      rf_data_in      <= '0;
      rf_bit_op       <= '0;
      rf_bit_position <= '0;
    end else begin
      rf_read_addr_0  <= read_addr_0_d;
      rf_read_addr_1  <= read_addr_1_d;
      done            <= done_d;
      err             <= err_d;
      rf_write_en     <= write_en_d;
      rf_swap_en      <= swap_en_d;
      rf_bit_op_en    <= bit_op_en_d;
      rf_write_addr   <= write_addr_d;
      rf_data_in      <= data_in_d;
      rf_bit_op       <= bit_op_d;
      rf_bit_position <= bit_position_d;
    end
  end

  // NOTE: datapath capture registers carry no reset; each is written before it is ever consumed.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= instr[OP_MSB:OP_LSB];
      rd_q   <= instr[RD_MSB:RD_LSB];
      imm8_q <= instr[IMM_MSB:IMM_LSB];
    end
    if (state == ST_READ) begin
      opa_q <= rf_read_data_0;
      opb_q <= rf_read_data_1;
    end
  end

  regfile_seq_alu u_alu (
    .op     (op_q),
    .opa    (opa_q),
    .opb    (opb_q),
    .imm8   (imm8_q),
    .bitpos (imm8_q[BITPOS_W-1:0]),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

`ifdef SEQ_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else if (state == ST_EXEC && updates_flags(op_q)) begin
      zero_flag  <= alu_zero;
      carry_flag <= alu_carry;
    end
  end
`else
  logic unused_alu_flags;
  assign unused_alu_flags = alu_zero ^ alu_carry;
  assign zero_flag  = 1'b0;
  assign carry_flag = 1'b0;
`endif

endmodule
